zone_light_controller: RTL and testbench
========================================

# zone_light_controller

Multi-zone successor to the single-room interior light controller. One shared ambient luminance sensor drives a hysteretic dark/bright decision, and each of N_ZONES zones has its own occupancy inputs (motion, IR) and manual override. Each zone runs an occupancy FSM with a programmable hold-off timer, so lights stay on for a bounded time after occupancy is lost. The block sits between the sensor front-end and the lighting drivers; outputs drive lamp enables directly.

## Interface
- N_ZONES, 4: number of independent zones (1..16).
- LUM_W, 8: luminance sensor width.
- DARK_ON, 8'h20: dark is set when sampled luminance < DARK_ON.
- DARK_OFF, 8'h30: dark is cleared when sampled luminance > DARK_OFF; DARK_OFF >= DARK_ON.
- HOLD_CYCLES, 16: cycles the light stays on after occupancy is lost (>= 1); counter width is $clog2(HOLD_CYCLES+1).

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- lum_sen  in  LUM_W  ambient luminance, unsigned.
- motion_sen  in  N_ZONES  per-zone motion detect.
- ir_sen  in  N_ZONES  per-zone IR presence.
- manual  in  N_ZONES  per-zone manual force-on.
- int_light  out  N_ZONES  per-zone lamp enable.
- dark  out  1  registered hysteretic dark flag.
- zone_state  out  2*N_ZONES  per-zone FSM state, zone i at bits [2i+1:2i].

## Operation
- Input stage: lum_q, pres_q = motion_sen | ir_sen, and man_q are registered every edge.
- Dark flag: set if lum_q < DARK_ON, cleared if lum_q > DARK_OFF, otherwise held. Comparisons are unsigned.
- Per-zone FSM, encodings OFF=00, ON=01, HOLD=10, MANUAL=11. Conditions are evaluated in priority order.
  - OFF: man_q goes to MANUAL; else pres_q && dark goes to ON; else stays OFF.
  - ON: man_q goes to MANUAL; else !dark goes to OFF; else !pres_q goes to HOLD with cnt loaded to HOLD_CYCLES-1; else stays ON.
  - HOLD: man_q goes to MANUAL; else !dark goes to OFF; else pres_q goes to ON; else cnt==0 goes to OFF; else cnt decrements.
  - MANUAL: man_q stays MANUAL; otherwise goes to OFF, and normal evaluation resumes from OFF on the following edge.
- int_light[i] = 1 in ON, HOLD and MANUAL, and 0 in OFF. It is decoded from the state register, so the output is glitch-free.
- Zones are fully independent. Only dark is shared.
- MANUAL ignores luminance, so lights turn on even when bright.

## Timing
- Reset (reset=0), asynchronous. Values forced:
  - lum_q=0, pres_q=0, man_q=0, dark=0.
  - All zones OFF, cnt=0.
  - int_light=0, zone_state=0.
- A reset asserted mid-HOLD or mid-MANUAL drops int_light immediately, without waiting for a clock edge.
- Presence to light, when dark is already 1: the input is sampled at edge n, the state changes at edge n+1, and int_light=1 after edge n+1.
- Luminance to light, with presence already held: lum_q updates at edge n, dark at edge n+1, zone state at edge n+2.
- Manual to light: 2 edges. Manual release to light off: 2 edges.
- Hold duration: the ON to HOLD transition happens at edge m. int_light falls after edge m+HOLD_CYCLES if no presence returns in between.
- Retrigger: pres_q=1 on any HOLD edge returns the zone to ON. The count restarts on the next loss of presence.
- Simultaneous events: manual beats everything, and !dark beats presence and the timer. Presence re-arriving on the edge where cnt==0 goes to ON, not OFF.
- Luminance exactly equal to DARK_ON or DARK_OFF does not change dark.

## Test plan
Parameters are left at their defaults.
- Reset: release reset with lum_sen=8'h80 and no presence. Required: dark=0, int_light=4'b0000, zone_state=8'h00. Then assert reset during HOLD. Required: int_light=0 with no clock edge.
- Hysteresis: drive lum_sen 8'h80, then 8'h08, then 8'h28, then 8'h80, then 8'h28. Required dark sequence: 0, 1, 1 (held), 0, 0 (held). Also drive 8'h20 while dark=0; required: dark stays 0.
- Occupancy: dark=1 and motion_sen[0]=1. Required: int_light[0]=1 two edges after sampling, and other zones stay 0. Then drop motion. Required: int_light[0] stays 1 for exactly 16 cycles after HOLD entry, then 0 with zone_state[1:0]=00.
- Retrigger: in HOLD at cnt=5, pulse ir_sen[0] for one cycle. Required: zone 0 returns to ON (zone_state[1:0]=01), then a fresh 16-cycle hold begins after the pulse ends.
- Manual: lum_sen=8'h80 and manual[2]=1. Required: int_light[2]=1 and zone_state[5:4]=11. Release manual. Required: int_light[2]=0 two edges later.
- Daylight kill: zones 1 and 3 are ON or in HOLD, then lum_sen goes 8'h08 to 8'h80 with presence held. Required: both zones go to OFF one edge after dark falls.

Source files
------------

// File: rtl/zone_light_controller.sv
// zone_light_controller
// Multi-zone interior light controller. A shared ambient luminance sensor feeds
// a hysteretic dark/bright decision; every zone runs its own occupancy FSM with
// a hold-off timer and a manual force-on. Lamp enables are decoded straight
// from the state registers, so they are glitch-free and fall as soon as the
// asynchronous reset asserts.
module zone_light_controller #(
  parameter int unsigned      N_ZONES     = 4,
  parameter int unsigned      LUM_W       = 8,
  parameter logic [LUM_W-1:0] DARK_ON     = 8'h20,
  parameter logic [LUM_W-1:0] DARK_OFF    = 8'h30,
  parameter int unsigned      HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LUM_W-1:0]     lum_sen,
  input  logic [N_ZONES-1:0]   motion_sen,
  input  logic [N_ZONES-1:0]   ir_sen,
  input  logic [N_ZONES-1:0]   manual,
  output logic [N_ZONES-1:0]   int_light,
  output logic                 dark,
  output logic [2*N_ZONES-1:0] zone_state
);

  localparam int unsigned      CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_ON     = 2'b01,
    ST_HOLD   = 2'b10,
    ST_MANUAL = 2'b11
  } zone_st_t;

  // Registered input stage
  logic [LUM_W-1:0]   r_lum_q;
  logic [N_ZONES-1:0] r_pres_q;
  logic [N_ZONES-1:0] r_man_q;

  // Shared dark flag
  logic r_dark;

  // Per-zone FSM state and hold-off counters
  zone_st_t         r_state   [N_ZONES];
  logic [CNT_W-1:0] r_cnt     [N_ZONES];
  zone_st_t         w_state_nx[N_ZONES];
  logic [CNT_W-1:0] w_cnt_nx  [N_ZONES];

  // Sample sensors and manual switches; motion and IR merge into one presence bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lum_q  <= '0;
      r_pres_q <= '0;
      r_man_q  <= '0;
    end else begin
      r_lum_q  <= lum_sen;
      r_pres_q <= motion_sen | ir_sen;
      r_man_q  <= manual;
    end
  end

  // Hysteretic dark decision on the registered luminance; the band between the
  // thresholds (inclusive of both) holds the previous value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dark <= 1'b0;
    end else if (r_lum_q < DARK_ON) begin
      r_dark <= 1'b1;
    end else if (r_lum_q > DARK_OFF) begin
      r_dark <= 1'b0;
    end
  end

  // Zone state and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_ZONES; i++) begin
        r_state[i] <= ST_OFF;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_ZONES; i++) begin
        r_state[i] <= w_state_nx[i];
        r_cnt[i]   <= w_cnt_nx[i];
      end
    end
  end

  // Next-state logic per zone; manual first, then loss of darkness, then
  // presence, then the hold-off timer.
  always_comb begin
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      w_state_nx[i] = r_state[i];
      w_cnt_nx[i]   = r_cnt[i];
      unique case (r_state[i])
        ST_OFF: begin
          if (r_man_q[i]) begin
            w_state_nx[i] = ST_MANUAL;
          end else if (r_pres_q[i] && r_dark) begin
            w_state_nx[i] = ST_ON;
          end
        end
        ST_ON: begin
          if (r_man_q[i]) begin
            w_state_nx[i] = ST_MANUAL;
          end else if (!r_dark) begin
            w_state_nx[i] = ST_OFF;
          end else if (!r_pres_q[i]) begin
            w_state_nx[i] = ST_HOLD;
            w_cnt_nx[i]   = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (r_man_q[i]) begin
            w_state_nx[i] = ST_MANUAL;
          end else if (!r_dark) begin
            w_state_nx[i] = ST_OFF;
          end else if (r_pres_q[i]) begin
            w_state_nx[i] = ST_ON;
          end else if (r_cnt[i] == '0) begin
            w_state_nx[i] = ST_OFF;
          end else begin
            w_cnt_nx[i] = r_cnt[i] - 1'b1;
          end
        end
        ST_MANUAL: begin
          if (!r_man_q[i]) begin
            w_state_nx[i] = ST_OFF;
          end
        end
        default: begin
          w_state_nx[i] = ST_OFF;
        end
      endcase
    end
  end

  // Output decode straight from registers.
  always_comb begin
    int_light  = '0;
    zone_state = '0;
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      int_light[i]         = (r_state[i] != ST_OFF);
      zone_state[2*i +: 2] = r_state[i];
    end
  end

  assign dark = r_dark;

endmodule

// File: tb/tb_zone_light_controller.sv
// Testbench for zone_light_controller: table of single-step vectors followed by
// hand-written multi-cycle sequences, with expected outputs queued on drive and
// compared after the stated number of clock edges.
module tb_zone_light_controller;

  logic       clk;
  logic       reset;
  logic [7:0] lum_sen;
  logic [3:0] motion_sen;
  logic [3:0] ir_sen;
  logic [3:0] manual;
  logic [3:0] int_light;
  logic       dark;
  logic [7:0] zone_state;

  zone_light_controller #(
    .N_ZONES    (4),
    .LUM_W      (8),
    .DARK_ON    (8'h20),
    .DARK_OFF   (8'h30),
    .HOLD_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lum_sen   (lum_sen),
    .motion_sen(motion_sen),
    .ir_sen    (ir_sen),
    .manual    (manual),
    .int_light (int_light),
    .dark      (dark),
    .zone_state(zone_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  lum;
    logic [3:0]  mot;
    logic [3:0]  ir;
    logic [3:0]  man;
    int unsigned edges;
    logic [3:0]  light;
    logic        drk;
    logic [7:0]  st;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] light;
    logic       drk;
    logic [7:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic apply(input string name, input int unsigned edges,
                       input logic [3:0] light, input logic drk, input logic [7:0] st);
    exp_t e;
    exp_t got;
    e.name = name; e.light = light; e.drk = drk; e.st = st;
    sb.push_back(e);
    if (edges > 0) begin
      repeat (edges) @(posedge clk);
      @(negedge clk);
    end else begin
      #1;
    end
    got = sb.pop_front();
    n_total++;
    if (int_light === got.light && dark === got.drk && zone_state === got.st) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got light=%b dark=%b state=%h, expected light=%b dark=%b state=%h",
               got.name, int_light, dark, zone_state, got.light, got.drk, got.st);
    end
  endtask

  task automatic hold_run(input string name);
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) apply(name, 1, 4'b0001, 1'b1, 8'h02);
      else        apply(name, 1, 4'b0000, 1'b1, 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"hyst_80",    8'h80, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b0, 8'h00};
    vecs[1]  = '{"hyst_08",    8'h08, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b1, 8'h00};
    vecs[2]  = '{"hyst_28",    8'h28, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b1, 8'h00};
    vecs[3]  = '{"hyst_80b",   8'h80, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b0, 8'h00};
    vecs[4]  = '{"hyst_28b",   8'h28, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b0, 8'h00};
    vecs[5]  = '{"eq_dark_on", 8'h20, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b0, 8'h00};
    vecs[6]  = '{"below_on",   8'h1F, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b1, 8'h00};
    vecs[7]  = '{"eq_dark_off",8'h30, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b1, 8'h00};
    vecs[8]  = '{"above_off",  8'h31, 4'h0, 4'h0, 4'h0,   2, 4'b0000, 1'b0, 8'h00};
    vecs[9]  = '{"man_on",     8'h80, 4'h0, 4'h0, 4'b0100, 2, 4'b0100, 1'b0, 8'h30};
    vecs[10] = '{"man_rel_1",  8'h80, 4'h0, 4'h0, 4'h0,   1, 4'b0100, 1'b0, 8'h30};
    vecs[11] = '{"man_rel_2",  8'h80, 4'h0, 4'h0, 4'h0,   1, 4'b0000, 1'b0, 8'h00};

    reset = 1'b0; lum_sen = 8'h80; motion_sen = '0; ir_sen = '0; manual = '0;
    @(negedge clk);
    apply("reset_state", 0, 4'b0000, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    apply("post_reset", 3, 4'b0000, 1'b0, 8'h00);

    for (int v = 0; v < 12; v++) begin
      lum_sen = vecs[v].lum; motion_sen = vecs[v].mot;
      ir_sen  = vecs[v].ir;  manual     = vecs[v].man;
      apply(vecs[v].name, vecs[v].edges, vecs[v].light, vecs[v].drk, vecs[v].st);
    end

    // Occupancy and full hold-off
    lum_sen = 8'h08;
    apply("occ_dark", 2, 4'b0000, 1'b1, 8'h00);
    motion_sen = 4'b0001;
    apply("occ_sampled", 1, 4'b0000, 1'b1, 8'h00);
    apply("occ_on", 1, 4'b0001, 1'b1, 8'h01);
    motion_sen = 4'b0000;
    apply("occ_still_on", 1, 4'b0001, 1'b1, 8'h01);
    apply("occ_hold_entry", 1, 4'b0001, 1'b1, 8'h02);
    hold_run("occ_hold");

    // Retrigger from HOLD at cnt=5
    motion_sen = 4'b0001;
    apply("rt_on", 2, 4'b0001, 1'b1, 8'h01);
    motion_sen = 4'b0000;
    apply("rt_hold", 2, 4'b0001, 1'b1, 8'h02);
    apply("rt_cnt5", 10, 4'b0001, 1'b1, 8'h02);
    ir_sen = 4'b0001;
    apply("rt_pulse", 1, 4'b0001, 1'b1, 8'h02);
    ir_sen = 4'b0000;
    apply("rt_back_on", 1, 4'b0001, 1'b1, 8'h01);
    apply("rt_hold_again", 1, 4'b0001, 1'b1, 8'h02);
    hold_run("rt_hold");

    // Presence arriving on the cnt==0 edge goes back to ON
    motion_sen = 4'b0001;
    apply("c0_on", 2, 4'b0001, 1'b1, 8'h01);
    motion_sen = 4'b0000;
    apply("c0_hold", 2, 4'b0001, 1'b1, 8'h02);
    apply("c0_cnt1", 14, 4'b0001, 1'b1, 8'h02);
    motion_sen = 4'b0001;
    apply("c0_cnt0", 1, 4'b0001, 1'b1, 8'h02);
    apply("c0_reon", 1, 4'b0001, 1'b1, 8'h01);
    motion_sen = 4'b0000;
    apply("c0_hold2", 2, 4'b0001, 1'b1, 8'h02);

    // Asynchronous reset during HOLD, checked before the next rising edge
    #2 reset = 1'b0;
    apply("async_reset", 0, 4'b0000, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Daylight kill of ON zone 1 and HOLD zone 3
    lum_sen = 8'h08; motion_sen = 4'b1010;
    apply("dk_on", 3, 4'b1010, 1'b1, 8'h44);
    motion_sen = 4'b0010;
    apply("dk_z3_hold", 2, 4'b1010, 1'b1, 8'h84);
    lum_sen = 8'h80;
    apply("dk_dark_fall", 2, 4'b1010, 1'b0, 8'h84);
    apply("dk_off", 1, 4'b0000, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
